// File: rtl/multiplier_bist.sv
// Built-in self-test for a 4x4 combinational multiplier: sweeps all 256 operand
// pairs and checks each captured product against a 4-cycle shift-add reference.
module multiplier_bist #(
    parameter int SETTLE      = 1,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] p_in,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic       first_err_valid,
    output logic [7:0] first_err_addr
);

    typedef enum logic [2:0] {IDLE, DRIVE, CALC, CHECK, DONE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [3:0] settle_q, settle_d;
    logic [1:0] calc_q, calc_d;
    logic [7:0] p_cap_q, p_cap_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] mcand_q, mcand_d;
    logic [3:0] mplier_q, mplier_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [8:0] err_q, err_d;
    logic       fev_q, fev_d;
    logic [7:0] fea_q, fea_d;
    logic       mismatch;

    assign mismatch = (p_cap_q != acc_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        calc_d   = calc_q;
        p_cap_d  = p_cap_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fea_d    = fea_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = 8'd0;
                    settle_d = 4'd0;
                    err_d    = 9'd0;
                    fev_d    = 1'b0;
                    fea_d    = 8'd0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                end
            end
            DRIVE: begin
                // p_in is only trusted once operands have been held SETTLE cycles
                if (settle_q == SETTLE_LAST) begin
                    p_cap_d  = p_in;
                    acc_d    = 8'd0;
                    mcand_d  = {4'b0, idx_q[7:4]};
                    mplier_d = idx_q[3:0];
                    calc_d   = 2'd0;
                    state_d  = CALC;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            CALC: begin
                if (mplier_q[0])
                    acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                calc_d   = calc_q + 2'd1;
                if (calc_q == 2'd3)
                    state_d = CHECK;
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 9'd1;
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fea_d = idx_q;
                    end
                end
                if (idx_q == 8'hFF || (STOP_ON_ERR && mismatch)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 9'd0);
                end else begin
                    idx_d    = idx_q + 8'd1;
                    settle_d = 4'd0;
                    state_d  = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            idx_q    <= 8'd0;
            settle_q <= 4'd0;
            calc_q   <= 2'd0;
            p_cap_q  <= 8'd0;
            acc_q    <= 8'd0;
            mcand_q  <= 8'd0;
            mplier_q <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 9'd0;
            fev_q    <= 1'b0;
            fea_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            calc_q   <= calc_d;
            p_cap_q  <= p_cap_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fea_q    <= fea_d;
        end
    end

    assign a_out           = idx_q[7:4];
    assign b_out           = idx_q[3:0];
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_addr  = fea_q;

endmodule

// File: tb/tb_multiplier_bist.sv
// Scoreboard bench: three BIST instances each driving a behavioural multiplier
// (ideal, p[0] stuck-at-0, or 2-cycle lag); done rising edges are checked against queued results.
module tb_multiplier_bist;

    typedef struct {
        int id; int t0; int lat; int ps; int ec; int fv; int fa;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] rst = 3'b111;
    logic [2:0] start = 3'b000;
    logic [7:0] p [3];
    logic [7:0] prod [3];
    logic [7:0] pd1 [3];
    logic [7:0] pd2 [3];
    int         mode [3];
    logic [3:0] a_o [3];
    logic [3:0] b_o [3];
    logic [2:0] busy_o, done_o, pass_o, fev_o;
    logic [2:0] done_prev = 3'b000;
    logic [8:0] err_o [3];
    logic [7:0] fea_o [3];

    exp_t sb[$];
    int   cyc = 0;
    int   t0 = 0;
    int   npass = 0;
    int   ntot = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiplier_bist #(.SETTLE(1), .STOP_ON_ERR(1'b0)) u0 (
        .CLK(clk), .RST(rst[0]), .start(start[0]), .p_in(p[0]), .a_out(a_o[0]), .b_out(b_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(err_o[0]),
        .first_err_valid(fev_o[0]), .first_err_addr(fea_o[0]));
    multiplier_bist #(.SETTLE(1), .STOP_ON_ERR(1'b1)) u1 (
        .CLK(clk), .RST(rst[1]), .start(start[1]), .p_in(p[1]), .a_out(a_o[1]), .b_out(b_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(err_o[1]),
        .first_err_valid(fev_o[1]), .first_err_addr(fea_o[1]));
    multiplier_bist #(.SETTLE(3), .STOP_ON_ERR(1'b0)) u2 (
        .CLK(clk), .RST(rst[2]), .start(start[2]), .p_in(p[2]), .a_out(a_o[2]), .b_out(b_o[2]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_count(err_o[2]),
        .first_err_valid(fev_o[2]), .first_err_addr(fea_o[2]));

    // mode 0: ideal, 1: p[0] stuck at 0, 2: product lags operands by 2 cycles
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            prod[k] = {4'b0, a_o[k]} * {4'b0, b_o[k]};
            p[k] = prod[k];
            if (mode[k] == 1) p[k] = prod[k] & 8'hFE;
            else if (mode[k] == 2) p[k] = pd2[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            pd1[k] <= prod[k];
            pd2[k] <= pd1[k];
        end
    end

    function automatic void chk(input string nm, input int act, input int exp_v);
        ntot++;
        if (act == exp_v) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    endfunction

    always @(negedge clk) begin : monitor
        int   hit;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (done_o[k] && !done_prev[k]) begin
                hit = -1;
                for (int j = 0; j < sb.size(); j++)
                    if (hit < 0 && sb[j].id == k) hit = j;
                if (hit < 0) begin
                    chk($sformatf("dut%0d_unexpected_done", k), 1, 0);
                end else begin
                    e = sb[hit];
                    sb.delete(hit);
                    chk($sformatf("dut%0d_latency", k), cyc - e.t0, e.lat);
                    chk($sformatf("dut%0d_pass", k), int'(pass_o[k]), e.ps);
                    chk($sformatf("dut%0d_err_count", k), int'(err_o[k]), e.ec);
                    chk($sformatf("dut%0d_first_err_valid", k), int'(fev_o[k]), e.fv);
                    chk($sformatf("dut%0d_first_err_addr", k), int'(fea_o[k]), e.fa);
                end
            end
        end
        done_prev <= done_o;
    end

    task automatic kick(input logic [2:0] m);
        @(negedge clk);
        start = m;
        t0 = cyc + 1;
        @(negedge clk);
        start = 3'b000;
    endtask

    task automatic push(input int id, input int lat, input int ps, input int ec,
                        input int fv, input int fa);
        sb.push_back('{id, t0, lat, ps, ec, fv, fa});
    endtask

    task automatic wait_all();
        for (int i = 0; i < 5000; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            chk("timeout_pending_results", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk($sformatf("%s%0d_ab", tag, k), int'({a_o[k], b_o[k]}), 0);
        chk($sformatf("%s%0d_busy", tag, k), int'(busy_o[k]), 0);
        chk($sformatf("%s%0d_done", tag, k), int'(done_o[k]), 0);
        chk($sformatf("%s%0d_pass", tag, k), int'(pass_o[k]), 0);
        chk($sformatf("%s%0d_err", tag, k), int'(err_o[k]), 0);
        chk($sformatf("%s%0d_fev", tag, k), int'(fev_o[k]), 0);
        chk($sformatf("%s%0d_fea", tag, k), int'(fea_o[k]), 0);
    endtask

    initial begin
        mode[0] = 0; mode[1] = 1; mode[2] = 2;
        repeat (3) @(negedge clk);
        rst = 3'b000;
        for (int k = 0; k < 3; k++) chk_idle(k, "reset");

        // Sweep A: ideal / stuck-at with stop / lagging product with SETTLE=3
        kick(3'b111);
        for (int k = 0; k < 3; k++) chk($sformatf("busy_after_start%0d", k), int'(busy_o[k]), 1);
        push(0, 1536, 1, 0, 0, 0);
        push(1, 108, 0, 1, 1, 8'h11);
        push(2, 2048, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            repeat (37 + 13 * i) @(negedge clk);
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
        end
        wait_all();
        chk("stop_held_ab", int'({a_o[1], b_o[1]}), 8'h11);
        chk("stop_still_done", int'(done_o[1]), 1);

        // Sweep B: restart from DONE; dut1 error count must clear
        mode[0] = 1; mode[1] = 0; mode[2] = 0;
        kick(3'b111);
        chk("restart_err_cleared", int'(err_o[1]), 0);
        chk("restart_fev_cleared", int'(fev_o[1]), 0);
        chk("restart_busy", int'(busy_o[1]), 1);
        push(0, 1536, 0, 64, 1, 8'h11);
        push(1, 1536, 1, 0, 0, 0);
        push(2, 2048, 1, 0, 0, 0);
        wait_all();

        // Sweep C: lag with SETTLE=1 fails (stale 0xFF product also hits 0x00); reset dut1 mid-sweep
        mode[0] = 2; mode[1] = 0;
        kick(3'b011);
        push(0, 1536, 0, 240, 1, 8'h00);
        repeat (498) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk_idle(1, "midreset");
        repeat (3) @(negedge clk);
        chk("midreset_stays_idle", int'({busy_o[1], done_o[1]}), 0);
        kick(3'b010);
        push(1, 1536, 1, 0, 0, 0);
        wait_all();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
